// File: rtl/dma_stats_mc_pkg.sv
// dma_stats_mc_pkg: stat indices and shared defaults for the DMA statistics block
package dma_stats_mc_pkg;
  localparam int N_STAT = 10;
  localparam int STAT_RD_REQ = 0;
  localparam int STAT_WR_REQ = 1;
  localparam int STAT_RD_DONE = 2;
  localparam int STAT_WR_DONE = 3;
  localparam int STAT_AXIS_RD = 4;
  localparam int STAT_AXIS_WR = 5;
  localparam int STAT_RD_OUTST = 6;
  localparam int STAT_WR_OUTST = 7;
  localparam int STAT_RD_PEAK = 8;
  localparam int STAT_WR_PEAK = 9;
  localparam int STATS_DELAY_DEF = 2;
endpackage

// File: rtl/dma_stat_chan.sv
// dma_stat_chan: one channel's event, outstanding and peak counters with sticky underflow
module dma_stat_chan
  import dma_stats_mc_pkg::*;
#(
  parameter int CNT_BITS = 32,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_req,
  input  logic                       wr_req,
  input  logic                       rd_done,
  input  logic                       wr_done,
  input  logic                       axis_rd,
  input  logic                       axis_wr,
  input  logic                       clr,
  output logic [N_STAT*CNT_BITS-1:0] cnt_o,
  output logic                       underflow_o
);
  localparam logic [CNT_BITS-1:0] ONES = '1;
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);
  logic [CNT_BITS-1:0] cnt_q [N_STAT];
  logic [CNT_BITS-1:0] cnt_d [N_STAT];
  logic                uf_q, uf_d;
  logic [5:0]          ev;
  assign ev = {axis_wr, axis_rd, wr_done, rd_done, wr_req, rd_req};
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == ONES) ? v : v + ONE;
  endfunction
  // d=0 is the read direction, d=1 the write direction; req/done indices are two apart
  always_comb begin
    cnt_d = cnt_q;
    uf_d = uf_q;
    for (int k = 0; k < 6; k++)
      if (ev[k]) cnt_d[k] = (SATURATE != 0) ? sat_inc(cnt_q[k]) : cnt_q[k] + ONE;
    for (int d = 0; d < 2; d++) begin
      cnt_d[STAT_RD_OUTST+d] = (ev[STAT_RD_REQ+d] && !ev[STAT_RD_DONE+d]) ? sat_inc(cnt_q[STAT_RD_OUTST+d]) :
                               (ev[STAT_RD_DONE+d] && !ev[STAT_RD_REQ+d] && cnt_q[STAT_RD_OUTST+d] != '0) ?
                               cnt_q[STAT_RD_OUTST+d] - ONE : cnt_q[STAT_RD_OUTST+d];
      cnt_d[STAT_RD_PEAK+d] = (cnt_d[STAT_RD_OUTST+d] > cnt_q[STAT_RD_PEAK+d]) ?
                              cnt_d[STAT_RD_OUTST+d] : cnt_q[STAT_RD_PEAK+d];
      uf_d = uf_d | (ev[STAT_RD_DONE+d] && !ev[STAT_RD_REQ+d] && cnt_q[STAT_RD_OUTST+d] == '0);
    end
    if (clr) begin
      cnt_d = '{default: '0};
      uf_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      uf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      uf_q <= uf_d;
    end
  end
  for (genvar k = 0; k < N_STAT; k++) begin : g_out
    assign cnt_o[k*CNT_BITS +: CNT_BITS] = cnt_q[k];
  end
  assign underflow_o = uf_q;
endmodule

// File: rtl/dma_stats_mc.sv
// dma_stats_mc: multi-channel DMA statistics with delayed live view and atomic snapshot
module dma_stats_mc
  import dma_stats_mc_pkg::*;
#(
  parameter int N_CHAN = 4,
  parameter int CNT_BITS = 32,
  parameter int STATS_DELAY = STATS_DELAY_DEF,
  parameter int SATURATE = 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [N_CHAN-1:0]                 dma_rd_req,
  input  logic [N_CHAN-1:0]                 dma_rd_done,
  input  logic [N_CHAN-1:0]                 axis_rd,
  input  logic [N_CHAN-1:0]                 dma_wr_req,
  input  logic [N_CHAN-1:0]                 dma_wr_done,
  input  logic [N_CHAN-1:0]                 axis_wr,
  input  logic                              clr,
  input  logic                              snap,
  output logic [N_CHAN*N_STAT*CNT_BITS-1:0] stats_o,
  output logic [N_CHAN*N_STAT*CNT_BITS-1:0] snap_o,
  output logic                              snap_valid,
  output logic [N_CHAN-1:0]                 underflow_o
);
  localparam int CW = N_STAT*CNT_BITS;
  localparam int W = N_CHAN*CW;
  logic [W-1:0]             live;
  logic [W-1:0]             pipe_q [STATS_DELAY];
  logic [W-1:0]             pipe_d [STATS_DELAY];
  logic [STATS_DELAY-1:0]   sv_q, sv_d;
  logic [W-1:0]             snap_q, snap_d;
  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    dma_stat_chan #(.CNT_BITS(CNT_BITS), .SATURATE(SATURATE)) u_chan (
      .clk        (aclk),
      .rst        (areset),
      .rd_req     (dma_rd_req[c]),
      .wr_req     (dma_wr_req[c]),
      .rd_done    (dma_rd_done[c]),
      .wr_done    (dma_wr_done[c]),
      .axis_rd    (axis_rd[c]),
      .axis_wr    (axis_wr[c]),
      .clr        (clr),
      .cnt_o      (live[c*CW +: CW]),
      .underflow_o(underflow_o[c])
    );
  end
  // The snapshot rides the stats pipeline so snap_o lands with snap_valid
  always_comb begin
    pipe_d[0] = live;
    for (int i = 1; i < STATS_DELAY; i++) pipe_d[i] = pipe_q[i-1];
    sv_d = (sv_q << 1) | STATS_DELAY'(snap);
    snap_d = sv_d[STATS_DELAY-1] ? pipe_d[STATS_DELAY-1] : snap_q;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      pipe_q <= '{default: '0};
      sv_q <= '0;
      snap_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      sv_q <= sv_d;
      snap_q <= snap_d;
    end
  end
  assign stats_o = pipe_q[STATS_DELAY-1];
  assign snap_o = snap_q;
  assign snap_valid = sv_q[STATS_DELAY-1];
endmodule
